vga_sync_porch_gen: RTL
=======================

Name: vga_sync_porch_gen

Overview:
Parametrised successor to the fixed 640x480 porch stage. It takes raw active-region sync/video from the pulse generator and tracks column and row from the VSync frame edge. It regenerates HSync/VSync with configurable porches and selectable polarity, then blanks and aligns video to the new syncs. Lock status, an active-video flag, counts and a frame-start strobe are exported for downstream overlay logic. Sits between the sync-pulse generator and the VGA pins.

Parameters:
VIDEO_WIDTH, 4, bits per colour channel
TOTAL_COLS, 800, pixels per line incl. blanking
TOTAL_ROWS, 525, lines per frame incl. blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
FRONT_PORCH_HORZ, 18, pixels between active end and HSync start
BACK_PORCH_HORZ, 50, pixels between HSync end and line end
FRONT_PORCH_VERT, 10, lines between active end and VSync start
BACK_PORCH_VERT, 33, lines between VSync end and frame end
SYNC_ACTIVE_LOW, 1, 1: sync pulse driven 0; 0: pulse driven 1
EXTRA_DELAY, 0, extra pipeline stages on all outputs (0..7)

Ports:
clk  in  1  pixel clock
i_Reset  in  1  synchronous active-high reset
i_HSync  in  1  raw HSync, high during active columns
i_VSync  in  1  raw VSync, high during active rows
i_Red_Video / i_Grn_Video / i_Blu_Video  in  VIDEO_WIDTH each  pixel colour
o_HSync  out  1  porch-adjusted HSync
o_VSync  out  1  porch-adjusted VSync
o_Red_Video / o_Grn_Video / o_Blu_Video  out  VIDEO_WIDTH each  aligned, blanked colour
o_Active  out  1  high while the output pixel is in the active area
o_Col_Count  out  10  column of the output pixel
o_Row_Count  out  10  row of the output pixel
o_Frame_Start  out  1  one-cycle pulse aligned to pixel (0,0)
o_Locked  out  1  high after the first frame edge following reset

Behaviour:
- Clock and reset: one clock, clk. i_Reset is synchronous and active-high.
- Reset values:
  - Internal col/row = 0; lock = 0.
  - Delay lines cleared to their reset values.
  - o_HSync and o_VSync = inactive level (= SYNC_ACTIVE_LOW).
  - Colour outputs = 0; o_Active = 0; o_Col_Count and o_Row_Count = 0.
  - o_Frame_Start = 0; o_Locked = 0.
- Frame edge: i_VSync sampled 0 on the previous cycle and 1 on this cycle (i_VSync is registered internally for the compare).
  - On a frame edge: col <= 0, row <= 0, lock <= 1.
- Otherwise the counters advance:
  - col increments each cycle and wraps TOTAL_COLS-1 -> 0.
  - On the col wrap, row increments and wraps TOTAL_ROWS-1 -> 0.
  - The frame edge overrides the wrap when both occur in the same cycle.
  - Internal col/row always give the index of the pixel sampled on the previous cycle.
- Region decode on the counters (not on i_HSync), same stage:
  - Horizontal sync window: FRONT_PORCH_HORZ+ACTIVE_COLS <= col <= TOTAL_COLS-BACK_PORCH_HORZ-1.
  - Vertical sync window: FRONT_PORCH_VERT+ACTIVE_ROWS <= row <= TOTAL_ROWS-BACK_PORCH_VERT-1.
  - Active area: col < ACTIVE_COLS and row < ACTIVE_ROWS.
- Sync output: asserted level (!SYNC_ACTIVE_LOW) inside its window, inactive level outside.
- While unlocked:
  - Syncs are forced inactive.
  - o_Active = 0 and video is forced to 0.
  - o_Frame_Start = 0.
  - Counts still run and are output.
- Video: the input is delayed so that every output refers to the same pixel. Outside the active area the colour output = 0.
- Latency: 2 + EXTRA_DELAY cycles from the input sample to every output. All outputs are registered.
- o_Frame_Start = 1 exactly when the output pixel is (0,0) and lock = 1.
- Lock is not re-evaluated after it is set: a late or early VSync edge simply resyncs the counters; it never drops lock. Lock is cleared only by reset.
- Reset mid-frame: all state returns to its reset values next cycle. Lock is regained on the next frame edge.
- Count widths are 10 bits; TOTAL_COLS and TOTAL_ROWS are <= 1024. Comparisons are unsigned.

Test Plan:
- Reset: hold i_Reset 3 cycles, then drive i_VSync=1 steadily -> o_Locked=0, syncs=1, video=0, o_Active=0 throughout (no rising edge).
- Lock and frame: i_VSync 0->1 at cycle t, defaults -> o_Locked=1 and o_Frame_Start=1 at t+2 only. o_Col_Count=0, o_Row_Count=0 at t+2; o_Col_Count=1 at t+3.
- Horizontal windows (defaults): o_HSync=0 exactly for output cols 658..749 on every line; o_Active=1 only for cols 0..639 of rows 0..479.
- Vertical window: o_VSync=0 exactly for rows 490..491. Col 799 wraps to col 0 of the next row; row 524 wraps to row 0.
- Video and polarity: drive red=4'hA constantly with SYNC_ACTIVE_LOW=0 and EXTRA_DELAY=3:
  - o_Red_Video=4'hA for cols 0..639 and 0 at col 640.
  - o_HSync=1 only in cols 658..749.
  - Latency is 5 cycles.
- Resync and reset mid-frame:
  - VSync edge injected at internal row 100 -> counts restart at (0,0) with no loss of lock.
  - i_Reset asserted at row 200 -> o_Locked=0 next cycle and outputs at reset values.

Source files
------------

// File: rtl/vga_sync_porch_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_porch_gen                                           |
// | Description : Counter-based sync regeneration with porches, polarity,      |
// |               video blanking/alignment and lock/frame status.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_sync_porch_gen #(
  parameter int VIDEO_WIDTH      = 4,
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 18,
  parameter int BACK_PORCH_HORZ  = 50,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int BACK_PORCH_VERT  = 33,
  parameter int SYNC_ACTIVE_LOW  = 1,
  parameter int EXTRA_DELAY      = 0
) (
  input  logic                   clk,
  input  logic                   i_Reset,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Active,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic                   o_Frame_Start,
  output logic                   o_Locked
);

  typedef struct packed {
    logic                   hsync;
    logic                   vsync;
    logic [VIDEO_WIDTH-1:0] red;
    logic [VIDEO_WIDTH-1:0] grn;
    logic [VIDEO_WIDTH-1:0] blu;
    logic                   active;
    logic [9:0]             col;
    logic [9:0]             row;
    logic                   frame_start;
    logic                   locked;
  } out_t;

  localparam logic       c_sync_idle  = (SYNC_ACTIVE_LOW != 0);
  localparam logic [9:0] c_col_last   = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] c_row_last   = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] c_act_cols   = 10'(ACTIVE_COLS);
  localparam logic [9:0] c_act_rows   = 10'(ACTIVE_ROWS);
  localparam logic [9:0] c_hs_start   = 10'(FRONT_PORCH_HORZ + ACTIVE_COLS);
  localparam logic [9:0] c_hs_end     = 10'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam logic [9:0] c_vs_start   = 10'(FRONT_PORCH_VERT + ACTIVE_ROWS);
  localparam logic [9:0] c_vs_end     = 10'(TOTAL_ROWS - BACK_PORCH_VERT - 1);
  localparam out_t       c_out_reset  = {c_sync_idle, c_sync_idle, {(3*VIDEO_WIDTH+23){1'b0}}};

  // Raw HSync carries no information the counters do not already have.
  logic w_unused_hsync;
  assign w_unused_hsync = i_HSync;

  logic                   r_vsync_q;
  logic                   r_lock;
  logic [9:0]             r_col;
  logic [9:0]             r_row;
  logic [VIDEO_WIDTH-1:0] r_red;
  logic [VIDEO_WIDTH-1:0] r_grn;
  logic [VIDEO_WIDTH-1:0] r_blu;
  logic                   w_frame_edge;

  assign w_frame_edge = i_VSync & ~r_vsync_q;

  // Stage 1: track the position of the pixel being sampled. The VSync history
  // resets high so a level already high at reset release is not taken as an edge.
  always_ff @(posedge clk) begin
    if (i_Reset) begin
      r_vsync_q <= 1'b1;
      r_lock    <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
    end else begin
      r_vsync_q <= i_VSync;
      r_red     <= i_Red_Video;
      r_grn     <= i_Grn_Video;
      r_blu     <= i_Blu_Video;
      if (w_frame_edge) begin
        r_col  <= '0;
        r_row  <= '0;
        r_lock <= 1'b1;
      end else if (r_col == c_col_last) begin
        r_col <= '0;
        r_row <= (r_row == c_row_last) ? 10'd0 : r_row + 10'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  logic w_hs_win;
  logic w_vs_win;
  logic w_visible;
  out_t w_next;

  always_comb begin
    w_hs_win  = (r_col >= c_hs_start) && (r_col <= c_hs_end);
    w_vs_win  = (r_row >= c_vs_start) && (r_row <= c_vs_end);
    w_visible = r_lock && (r_col < c_act_cols) && (r_row < c_act_rows);

    w_next             = c_out_reset;
    w_next.hsync       = (r_lock && w_hs_win) ? ~c_sync_idle : c_sync_idle;
    w_next.vsync       = (r_lock && w_vs_win) ? ~c_sync_idle : c_sync_idle;
    w_next.red         = w_visible ? r_red : '0;
    w_next.grn         = w_visible ? r_grn : '0;
    w_next.blu         = w_visible ? r_blu : '0;
    w_next.active      = w_visible;
    w_next.col         = r_col;
    w_next.row         = r_row;
    w_next.frame_start = r_lock && (r_col == 10'd0) && (r_row == 10'd0);
    w_next.locked      = r_lock;
  end

  out_t r_out;

  always_ff @(posedge clk) begin
    if (i_Reset) begin
      r_out <= c_out_reset;
    end else begin
      r_out <= w_next;
    end
  end

  out_t w_final;

  generate
    if (EXTRA_DELAY > 0) begin : g_extra
      out_t r_pipe [EXTRA_DELAY];
      for (genvar gi = 0; gi < EXTRA_DELAY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            if (i_Reset) begin
              r_pipe[gi] <= c_out_reset;
            end else begin
              r_pipe[gi] <= r_out;
            end
          end
        end else begin : g_follow
          always_ff @(posedge clk) begin
            if (i_Reset) begin
              r_pipe[gi] <= c_out_reset;
            end else begin
              r_pipe[gi] <= r_pipe[gi-1];
            end
          end
        end
      end
      assign w_final = r_pipe[EXTRA_DELAY-1];
    end else begin : g_no_extra
      assign w_final = r_out;
    end
  endgenerate

  assign o_HSync       = w_final.hsync;
  assign o_VSync       = w_final.vsync;
  assign o_Red_Video   = w_final.red;
  assign o_Grn_Video   = w_final.grn;
  assign o_Blu_Video   = w_final.blu;
  assign o_Active      = w_final.active;
  assign o_Col_Count   = w_final.col;
  assign o_Row_Count   = w_final.row;
  assign o_Frame_Start = w_final.frame_start;
  assign o_Locked      = w_final.locked;

endmodule
`default_nettype wire
